// File: rtl/glitch_pkg.sv
// Shared types and widths for the glitch trigger controller.
// No ports; imported by the interface, the controller and the bench.
package glitch_pkg;

   localparam int unsigned DLY_W      = 24;  // delay and gap counters
   localparam int unsigned WID_W      = 16;  // pulse-width counter
   localparam int unsigned REP_W      = 8;   // pulse-repeat count
   localparam int unsigned TMO_W      = 32;  // trigger timeout counter
   localparam int unsigned TRIG_CNT_W = 16;  // accepted-trigger counter

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ARMED   = 3'd1,
      DELAY   = 3'd2,
      PULSE   = 3'd3,
      GAP     = 3'd4,
      DONE_ST = 3'd5
   } state_t;

endpackage

// File: rtl/glitch_trigger_ctrl_if.sv
// Control, configuration and status bundle of the glitch trigger controller.
// master: soft-core/GPIO side (drives arm, abort, cfg_*, trigger_in, pll_locked)
// slave : controller side (drives glitch_en, armed, busy, done, err, trig_count)
// GLITCH_TIMEOUT_EN adds cfg_timeout.
interface glitch_trigger_ctrl_if;
   import glitch_pkg::*;

   logic                  arm;
   logic                  abort;
   logic                  trigger_in;
   logic                  pll_locked;
   logic [DLY_W-1:0]      cfg_delay;
   logic [WID_W-1:0]      cfg_width;
   logic [DLY_W-1:0]      cfg_gap;
   logic [REP_W-1:0]      cfg_count;
`ifdef GLITCH_TIMEOUT_EN
   logic [TMO_W-1:0]      cfg_timeout;
`endif
   logic                  glitch_en;
   logic                  armed;
   logic                  busy;
   logic                  done;
   logic                  err;
   logic [TRIG_CNT_W-1:0] trig_count;

   modport master (
`ifdef GLITCH_TIMEOUT_EN
      output cfg_timeout,
`endif
      output arm, abort, trigger_in, pll_locked,
      output cfg_delay, cfg_width, cfg_gap, cfg_count,
      input  glitch_en, armed, busy, done, err, trig_count
   );

   modport slave (
`ifdef GLITCH_TIMEOUT_EN
      input  cfg_timeout,
`endif
      input  arm, abort, trigger_in, pll_locked,
      input  cfg_delay, cfg_width, cfg_gap, cfg_count,
      output glitch_en, armed, busy, done, err, trig_count
   );

endinterface

// File: rtl/sync_rise_detect.sv
// Two-flop synchronizer plus registered rising-edge pulse for a target GPIO.
// Ports: clk, reset (async, active-high), d (asynchronous input),
//        rise (one-cycle registered pulse on a synchronized 0->1 of d).
module sync_rise_detect (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic rise
);

   logic meta;
   logic sync;
   logic prev;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta <= 1'b0;
         sync <= 1'b0;
         prev <= 1'b0;
         rise <= 1'b0;
      end else begin
         meta <= d;
         sync <= meta;
         prev <= sync;
         rise <= sync & ~prev;
      end
   end

endmodule

// File: rtl/glitch_trigger_ctrl.sv
// Glitch timing controller: armed over GPIO, waits for a target trigger edge,
// counts a delay, then drives glitch_en for a width, optionally repeated with gaps.
// Ports: clk, reset (async, active-high), bus (glitch_trigger_ctrl_if.slave):
//   in : arm, abort, trigger_in, pll_locked, cfg_delay/width/gap/count
//   out: glitch_en, armed, busy, done, err, trig_count (all registered)
// Optional: GLITCH_TIMEOUT_EN adds cfg_timeout and an ARMED-state timeout.
module glitch_trigger_ctrl
   import glitch_pkg::*;
(
   input logic                 clk,
   input logic                 reset,
   glitch_trigger_ctrl_if.slave bus
);

   state_t                state;
   logic [DLY_W-1:0]      delay_q;
   logic [DLY_W-1:0]      gap_q;
   logic [WID_W-1:0]      width_q;
   logic [REP_W-1:0]      rem_q;
   logic [DLY_W-1:0]      cnt;
   logic                  glitch_en_q;
   logic                  armed_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  err_q;
   logic [TRIG_CNT_W-1:0] trig_count_q;
   logic                  trig_pulse;
   logic                  arm_ok;
   logic                  active;
`ifdef GLITCH_TIMEOUT_EN
   logic [TMO_W-1:0]      tmo_q;
   logic [TMO_W-1:0]      tcnt;
`endif

   sync_rise_detect u_trig_sync (
      .clk   (clk),
      .reset (reset),
      .d     (bus.trigger_in),
      .rise  (trig_pulse)
   );

   assign arm_ok = bus.arm && bus.pll_locked && ((state == IDLE) || (state == DONE_ST));
   assign active = (state == ARMED) || (state == DELAY) || (state == PULSE) || (state == GAP);

   // Single-process FSM; every output is a flop updated on its transition.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         delay_q      <= '0;
         gap_q        <= '0;
         width_q      <= '0;
         rem_q        <= '0;
         cnt          <= '0;
         glitch_en_q  <= 1'b0;
         armed_q      <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         trig_count_q <= '0;
`ifdef GLITCH_TIMEOUT_EN
         tmo_q        <= '0;
         tcnt         <= '0;
`endif
      end else if (bus.abort) begin
         state       <= IDLE;
         glitch_en_q <= 1'b0;
         armed_q     <= 1'b0;
         busy_q      <= 1'b0;
      end else if (active && !bus.pll_locked) begin
         // Losing lock mid-sequence would glitch with an unknown clock.
         state       <= IDLE;
         glitch_en_q <= 1'b0;
         armed_q     <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b1;
      end else begin
         case (state)
            IDLE, DONE_ST: begin
               if (arm_ok) begin
                  // Zero width/gap/count are treated as one.
                  delay_q <= bus.cfg_delay;
                  width_q <= (bus.cfg_width == '0) ? WID_W'(1) : bus.cfg_width;
                  gap_q   <= (bus.cfg_gap   == '0) ? DLY_W'(1) : bus.cfg_gap;
                  rem_q   <= (bus.cfg_count == '0) ? REP_W'(1) : bus.cfg_count;
                  done_q  <= 1'b0;
                  err_q   <= 1'b0;
                  armed_q <= 1'b1;
                  state   <= ARMED;
`ifdef GLITCH_TIMEOUT_EN
                  tmo_q   <= bus.cfg_timeout;
                  tcnt    <= '0;
`endif
               end
            end
            ARMED: begin
               if (trig_pulse) begin
                  trig_count_q <= trig_count_q + TRIG_CNT_W'(1);
                  armed_q      <= 1'b0;
                  busy_q       <= 1'b1;
                  if (delay_q == '0) begin
                     state       <= PULSE;
                     glitch_en_q <= 1'b1;
                     cnt         <= DLY_W'(width_q);
                  end else begin
                     state <= DELAY;
                     cnt   <= delay_q;
                  end
               end
`ifdef GLITCH_TIMEOUT_EN
               else if ((tmo_q != '0) && (tcnt == tmo_q - TMO_W'(1))) begin
                  state   <= IDLE;
                  armed_q <= 1'b0;
                  err_q   <= 1'b1;
               end else begin
                  tcnt <= tcnt + TMO_W'(1);
               end
`endif
            end
            DELAY: begin
               if (cnt == DLY_W'(1)) begin
                  state       <= PULSE;
                  glitch_en_q <= 1'b1;
                  cnt         <= DLY_W'(width_q);
               end else begin
                  cnt <= cnt - DLY_W'(1);
               end
            end
            PULSE: begin
               if (cnt == DLY_W'(1)) begin
                  glitch_en_q <= 1'b0;
                  if (rem_q > REP_W'(1)) begin
                     rem_q <= rem_q - REP_W'(1);
                     state <= GAP;
                     cnt   <= gap_q;
                  end else begin
                     state  <= DONE_ST;
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                  end
               end else begin
                  cnt <= cnt - DLY_W'(1);
               end
            end
            GAP: begin
               if (cnt == DLY_W'(1)) begin
                  state       <= PULSE;
                  glitch_en_q <= 1'b1;
                  cnt         <= DLY_W'(width_q);
               end else begin
                  cnt <= cnt - DLY_W'(1);
               end
            end
            default: begin
               state       <= IDLE;
               glitch_en_q <= 1'b0;
               armed_q     <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.glitch_en  = glitch_en_q;
   assign bus.armed      = armed_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.err        = err_q;
   assign bus.trig_count = trig_count_q;

endmodule

// File: tb/tb_glitch_trigger_ctrl.sv
// Self-checking bench for glitch_trigger_ctrl. Expected waveforms come from
// closed-form pulse timing: pulse i starts after edge delay+4+i*(width+gap).
module tb_glitch_trigger_ctrl;
   import glitch_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   n_pass = 0;
   int   n_total = 0;
   int   exp_trig = 0;

   glitch_trigger_ctrl_if bus ();

   glitch_trigger_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic test_reset();
      reset = 1'b1;
      bus.arm = 1'b0; bus.abort = 1'b0; bus.trigger_in = 1'b0; bus.pll_locked = 1'b1;
      bus.cfg_delay = '0; bus.cfg_width = '0; bus.cfg_gap = '0; bus.cfg_count = '0;
`ifdef GLITCH_TIMEOUT_EN
      bus.cfg_timeout = '0;
`endif
      repeat (3) @(negedge clk);
      n_total++;
      if ({bus.glitch_en, bus.armed, bus.busy, bus.done, bus.err} !== 5'b0 || bus.trig_count !== 16'd0)
         $display("FAIL reset: outputs=%b trig_count=%0d, want all 0",
                  {bus.glitch_en, bus.armed, bus.busy, bus.done, bus.err}, bus.trig_count);
      else n_pass++;
      reset = 1'b0;
      @(negedge clk);
   endtask

   // Trigger edges outside ARMED must not be counted.
   task automatic test_pretrigger();
      repeat (2) begin
         bus.trigger_in = 1'b1; repeat (4) @(negedge clk);
         bus.trigger_in = 1'b0; repeat (4) @(negedge clk);
      end
      n_total++;
      if (bus.trig_count !== 16'(exp_trig) || bus.armed !== 1'b0)
         $display("FAIL pretrigger: trig_count=%0d armed=%b, want %0d 0", bus.trig_count, bus.armed, exp_trig);
      else n_pass++;
   endtask

   // One arm/trigger transaction checked cycle by cycle against the timing formula.
   task automatic run_glitch(input int d, input int w, input int g, input int c, input string tag);
      int weff, geff, ceff, first, end_n, s;
      logic exp_g;
      logic [2:0] exp_st;
      weff = (w == 0) ? 1 : w;
      geff = (g == 0) ? 1 : g;
      ceff = (c == 0) ? 1 : c;
      first = d + 4;
      end_n = first + ceff * (weff + geff) - geff;
      bus.cfg_delay = DLY_W'(d); bus.cfg_width = WID_W'(w);
      bus.cfg_gap = DLY_W'(g);   bus.cfg_count = REP_W'(c);
      bus.arm = 1'b1;
      @(negedge clk);
      bus.arm = 1'b0;
      // Scramble config after arm; latched values must be used.
      bus.cfg_delay = DLY_W'($urandom_range(0, 30)); bus.cfg_width = WID_W'($urandom_range(0, 9));
      bus.cfg_gap = DLY_W'($urandom_range(0, 9));    bus.cfg_count = REP_W'($urandom_range(0, 5));
      n_total++;
      if ({bus.armed, bus.done, bus.err} !== 3'b100)
         $display("FAIL %s arm: armed,done,err=%b want 100", tag, {bus.armed, bus.done, bus.err});
      else n_pass++;
      bus.trigger_in = 1'b1;
      for (int n = 1; n <= end_n + 2; n++) begin
         @(negedge clk);
         exp_g = 1'b0;
         for (int i = 0; i < ceff; i++) begin
            s = first + i * (weff + geff);
            if (n >= s && n < s + weff) exp_g = 1'b1;
         end
         exp_st = {(n < 4) ? 1'b1 : 1'b0, (n >= 4 && n < end_n) ? 1'b1 : 1'b0, (n >= end_n) ? 1'b1 : 1'b0};
         n_total++;
         if (bus.glitch_en !== exp_g)
            $display("FAIL %s glitch_en edge %0d: got %b want %b", tag, n, bus.glitch_en, exp_g);
         else n_pass++;
         n_total++;
         if ({bus.armed, bus.busy, bus.done} !== exp_st)
            $display("FAIL %s status edge %0d: armed,busy,done=%b want %b", tag, n,
                     {bus.armed, bus.busy, bus.done}, exp_st);
         else n_pass++;
      end
      exp_trig++;
      n_total++;
      if (bus.trig_count !== 16'(exp_trig))
         $display("FAIL %s trig_count: got %0d want %0d", tag, bus.trig_count, exp_trig);
      else n_pass++;
      bus.trigger_in = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_basic();
      run_glitch(5, 3, 0, 1, "basic");
      run_glitch(0, 0, 2, 3, "multi");
   endtask

   task automatic test_random();
      for (int k = 0; k < 10; k++)
         run_glitch(int'($urandom_range(0, 20)), int'($urandom_range(0, 5)),
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), "random");
   endtask

   task automatic test_lock_loss();
      bus.cfg_delay = DLY_W'(2); bus.cfg_width = WID_W'(100); bus.cfg_gap = '0; bus.cfg_count = REP_W'(1);
      bus.arm = 1'b1; @(negedge clk); bus.arm = 1'b0;
      bus.trigger_in = 1'b1;
      repeat (10) @(negedge clk);
      exp_trig++;
      n_total++;
      if (bus.glitch_en !== 1'b1) $display("FAIL lock pulse: glitch_en=%b want 1", bus.glitch_en);
      else n_pass++;
      bus.pll_locked = 1'b0;
      @(negedge clk);
      n_total++;
      if ({bus.glitch_en, bus.err, bus.armed, bus.busy, bus.done} !== 5'b01000)
         $display("FAIL lock drop: glitch_en,err,armed,busy,done=%b want 01000",
                  {bus.glitch_en, bus.err, bus.armed, bus.busy, bus.done});
      else n_pass++;
      bus.arm = 1'b1; @(negedge clk); bus.arm = 1'b0; @(negedge clk);
      n_total++;
      if ({bus.armed, bus.err} !== 2'b01)
         $display("FAIL lock arm_ignored: armed,err=%b want 01", {bus.armed, bus.err});
      else n_pass++;
      bus.pll_locked = 1'b1; bus.trigger_in = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_abort_delay();
      int seen;
      seen = 0;
      bus.cfg_delay = DLY_W'(1000); bus.cfg_width = WID_W'(3); bus.cfg_count = REP_W'(1);
      bus.arm = 1'b1; @(negedge clk); bus.arm = 1'b0;
      bus.trigger_in = 1'b1;
      repeat (20) @(negedge clk);
      exp_trig++;
      n_total++;
      if (bus.busy !== 1'b1) $display("FAIL abort_delay busy: got %b want 1", bus.busy);
      else n_pass++;
      bus.abort = 1'b1; @(negedge clk); bus.abort = 1'b0;
      n_total++;
      if ({bus.armed, bus.busy, bus.done, bus.err} !== 4'b0000)
         $display("FAIL abort_delay state: armed,busy,done,err=%b want 0000",
                  {bus.armed, bus.busy, bus.done, bus.err});
      else n_pass++;
      for (int i = 0; i < 1100; i++) begin
         @(negedge clk);
         if (bus.glitch_en !== 1'b0) seen++;
      end
      n_total++;
      if (seen != 0) $display("FAIL abort_delay glitch: %0d high cycles, want 0", seen);
      else n_pass++;
      bus.trigger_in = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   // Abort lands on the same edge the delay counter would expire.
   task automatic test_abort_expiry();
      int seen;
      seen = 0;
      bus.cfg_delay = DLY_W'(6); bus.cfg_width = WID_W'(4); bus.cfg_count = REP_W'(1);
      bus.arm = 1'b1; @(negedge clk); bus.arm = 1'b0;
      bus.trigger_in = 1'b1;
      repeat (9) @(negedge clk);
      exp_trig++;
      bus.abort = 1'b1; @(negedge clk); bus.abort = 1'b0;
      n_total++;
      if ({bus.glitch_en, bus.busy, bus.armed} !== 3'b000)
         $display("FAIL abort_expiry edge10: glitch_en,busy,armed=%b want 000",
                  {bus.glitch_en, bus.busy, bus.armed});
      else n_pass++;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.glitch_en !== 1'b0) seen++;
      end
      n_total++;
      if (seen != 0) $display("FAIL abort_expiry glitch: %0d high cycles, want 0", seen);
      else n_pass++;
      bus.trigger_in = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   // Abort in DONE_ST keeps done; re-arm from DONE_ST clears it.
   task automatic test_back_to_back();
      run_glitch(1, 2, 1, 2, "b2b_first");
      bus.abort = 1'b1; @(negedge clk); bus.abort = 1'b0; @(negedge clk);
      n_total++;
      if (bus.done !== 1'b1) $display("FAIL b2b done_kept: got %b want 1", bus.done);
      else n_pass++;
      run_glitch(3, 1, 0, 1, "b2b_second");
      run_glitch(0, 2, 3, 2, "b2b_third");
   endtask

`ifdef GLITCH_TIMEOUT_EN
   task automatic test_timeout();
      bus.cfg_timeout = TMO_W'(50);
      bus.arm = 1'b1; @(negedge clk); bus.arm = 1'b0;
      bus.cfg_timeout = '0;
      repeat (49) @(negedge clk);
      n_total++;
      if ({bus.armed, bus.err} !== 2'b10) $display("FAIL timeout_49: armed,err=%b want 10", {bus.armed, bus.err});
      else n_pass++;
      @(negedge clk);
      n_total++;
      if ({bus.armed, bus.err} !== 2'b01) $display("FAIL timeout_50: armed,err=%b want 01", {bus.armed, bus.err});
      else n_pass++;
      bus.arm = 1'b1; @(negedge clk); bus.arm = 1'b0;
      repeat (10000) @(negedge clk);
      n_total++;
      if ({bus.armed, bus.err} !== 2'b10) $display("FAIL timeout_off: armed,err=%b want 10", {bus.armed, bus.err});
      else n_pass++;
      bus.abort = 1'b1; @(negedge clk); bus.abort = 1'b0;
      repeat (2) @(negedge clk);
   endtask
`endif

   initial begin
      test_reset();
      test_pretrigger();
      test_basic();
      test_random();
      test_lock_loss();
      test_abort_delay();
      test_abort_expiry();
      test_back_to_back();
`ifdef GLITCH_TIMEOUT_EN
      test_timeout();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/glitch_trigger_ctrl.md
Name: glitch_trigger_ctrl

Overview:
- Timing controller that decides when the fault clock is applied to the target.
- Sits directly upstream of the clock-mux/glitch output stage.
  - Waits for a trigger edge from the target board after being armed by the soft-core over GPIO.
  - Counts a programmable delay in system-clock cycles, then drives glitch_en for a programmable width.
  - Optionally repeats pulses with a programmable gap.
- glitch_en is the select line that swaps the clean clock for the PLL-derived glitch clock.

Parameters:
- DLY_W, 24, width of delay and gap counters (cycles of clk).
- WID_W, 16, width of pulse-width counter.
- REP_W, 8, width of pulse-repeat count.
- TMO_W, 32, width of trigger timeout counter (used only with GLITCH_TIMEOUT_EN).

Ports:
- clk  in  1  system clock; all logic is synchronous to it.
- reset  in  1  asynchronous, active-high reset.
- arm  in  1  single-cycle arm request.
- abort  in  1  single-cycle abort request.
- trigger_in  in  1  asynchronous trigger from target GPIO; rising edge is the event.
- pll_locked  in  1  glitch PLL lock status.
- cfg_delay  in  DLY_W  cycles from trigger detect to first pulse.
- cfg_width  in  WID_W  pulse width in cycles; 0 treated as 1.
- cfg_gap  in  DLY_W  low cycles between pulses; 0 treated as 1.
- cfg_count  in  REP_W  number of pulses; 0 treated as 1.
- glitch_en  out  1  registered glitch select.
- armed  out  1  high in ARMED.
- busy  out  1  high in DELAY, PULSE, GAP.
- done  out  1  sticky; set on normal completion.
- err  out  1  sticky; set on lock loss or timeout.
- trig_count  out  16  wrapping count of accepted trigger edges.

Behaviour:
- Reset: all outputs 0, state IDLE, synchronizer flops 0, trig_count 0.
- trigger_in path:
  - Passes through a 2-flop synchronizer plus a previous-value flop.
  - trig_pulse is registered: high for one cycle on a 0->1 of the synchronized signal.
  - Edges arriving outside ARMED are detected but ignored and not counted.
- cfg_* are latched on arm acceptance; later changes have no effect until the next arm.
- arm is accepted only in IDLE or DONE_ST with pll_locked=1; otherwise it is ignored.
- Acceptance clears done and err.
- States:
  - IDLE: waits for arm; accepted arm -> ARMED.
  - ARMED: on trig_pulse, trig_count++.
    - cfg_delay=0 -> PULSE.
    - Otherwise -> DELAY, with the counter loaded to cfg_delay.
  - DELAY: decrement each cycle; at 1 -> PULSE. Exactly cfg_delay cycles are spent in DELAY.
  - PULSE: glitch_en=1 for max(cfg_width,1) cycles, then:
    - pulses remaining > 0 -> GAP.
    - else -> DONE_ST, with done set.
  - GAP: glitch_en=0 for max(cfg_gap,1) cycles -> PULSE.
  - DONE_ST: same as IDLE for arm acceptance; done stays high.
- Latency:
  - glitch_en rises after clk edge cfg_delay+4.
  - Edge 1 is the first clk edge that samples trigger_in high, meeting setup.
- glitch_en is a flop output asserted only in PULSE; it must never glitch combinationally.
- abort, any state: next state IDLE, glitch_en=0 next cycle, done unchanged.
- pll_locked=0 in ARMED/DELAY/PULSE/GAP: next state IDLE, glitch_en=0, err=1.
- Simultaneous events, in priority order: reset > abort > lock loss > trig_pulse/counter expiry > arm.
- trig_count wraps 0xFFFF->0.
- Trigger edges while busy are ignored; the operation is single-shot per arm.

Optional Feature:
- GLITCH_TIMEOUT_EN defined:
  - Adds input cfg_timeout[TMO_W].
  - In ARMED, a counter runs from arm acceptance.
  - Reaching cfg_timeout with no trigger -> IDLE, err=1.
  - cfg_timeout=0 disables the timeout.
- Undefined: no port and no counter; ARMED waits indefinitely.

Decomposition:
- Package glitch_pkg: state enum (IDLE, ARMED, DELAY, PULSE, GAP, DONE_ST) and width constants.
- Sub-module sync_rise_detect: 2-flop synchronizer plus registered rising-edge pulse. It is reused for other target GPIO inputs.

Test Plan:
- Delay 5, width 3, count 1: arm, trigger high at edge 1 -> glitch_en high exactly during edges 9-11 outputs, done=1, trig_count=1.
- Delay 0, width 0, count 3, gap 2: trigger -> three 1-cycle pulses separated by 2 low cycles, first after edge 4, then done.
- pll_locked dropped mid-PULSE with width 100 -> glitch_en 0 next cycle, err=1, state IDLE; arm with pll_locked=0 is ignored.
- abort during DELAY with delay 1000 -> IDLE, no glitch_en ever; trigger edges before arm are not counted.
- Simultaneous abort and DELAY expiry -> abort wins, glitch_en stays 0.
- With GLITCH_TIMEOUT_EN, timeout 50 and no trigger -> err=1 at cycle 50 after arm; timeout 0 -> remains ARMED for 10000 cycles.
